// File: rtl/uart_pattern_gen.sv
// uart_pattern_gen
//   Test-pattern byte source for the en/rdy byte interface of uart_tx.
//   Produces a ramp, LFSR or constant payload stream, with optional CR/LF
//   line framing, an optional idle gap between bytes, and burst (count) or
//   continuous (count = 0, until stop) runs.
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   start     in   level, sampled in IDLE, begins a run
//   stop      in   level, ends the run once the byte in flight completes
//   mode      in   0 ramp, 1 LFSR, 2 constant FIRST_CHAR, 3 as 0 (latched)
//   count     in   payload bytes per run, 0 = continuous (latched)
//   rdy       in   uart_tx idle / able to accept a byte
//   en        out  single-cycle load strobe to uart_tx
//   data_out  out  byte to uart_tx, stable from en until rdy returns
//   busy      out  high whenever the generator is not idle
//   done      out  one-cycle pulse on return to idle after a run
//   sent_cnt  out  payload bytes sent this run (EOL bytes excluded)
module uart_pattern_gen #(
   parameter logic [7:0] FIRST_CHAR = 8'h41,
   parameter logic [7:0] LAST_CHAR  = 8'h57,
   parameter int         LINE_LEN   = 16,
   parameter bit         EOL_CR     = 1'b1,
   parameter int         GAP_CYCLES = 0,
   parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic [1:0]  mode,
   input  logic [15:0] count,
   input  logic        rdy,
   output logic        en,
   output logic [7:0]  data_out,
   output logic        busy,
   output logic        done,
   output logic [15:0] sent_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_ACC,
      S_WAIT_DONE,
      S_GAP
   } state_e;

   // What the byte currently on data_out is; drives EOL sequencing.
   typedef enum logic [1:0] {
      K_PAYLOAD,
      K_CR,
      K_LF
   } kind_e;

   localparam logic [7:0]  CHAR_CR    = 8'h0D;
   localparam logic [7:0]  CHAR_LF    = 8'h0A;
   localparam logic [15:0] LINE_LEN_V = 16'(LINE_LEN);
   localparam int          GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   // Gap counter runs GAP_CYCLES-1 down to 0, one GAP cycle per value.
   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

   // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting towards the MSB.
   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   state_e         state_q, state_d;
   kind_e          kind_q, kind_d;
   logic [1:0]     mode_q, mode_d;
   logic [15:0]    count_q, count_d;
   logic [15:0]    sent_q, sent_d;
   logic [15:0]    line_q, line_d;
   logic [7:0]     lfsr_q, lfsr_d;
   logic [7:0]     pay_q, pay_d;      // last payload byte issued
   logic [7:0]     data_q, data_d;
   logic           en_q, en_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [GAP_W-1:0] gap_q, gap_d;

   logic [15:0]    sent_inc;
   logic [15:0]    line_inc;
   logic [7:0]     nxt_pay;
   logic [7:0]     nxt_lfsr;
   logic           run_end;
   logic           eol_due;

   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      kind_d   = kind_q;
      mode_d   = mode_q;
      count_d  = count_q;
      sent_d   = sent_q;
      line_d   = line_q;
      lfsr_d   = lfsr_q;
      pay_d    = pay_q;
      data_d   = data_q;
      gap_d    = gap_q;
      en_d     = 1'b0;
      done_d   = 1'b0;

      // Counters as they stand once the byte in flight has completed.
      sent_inc = sent_q + 16'(kind_q == K_PAYLOAD);
      line_inc = line_q + 16'(kind_q == K_PAYLOAD);
      run_end  = ((count_q != 16'd0) && (sent_inc == count_q)) || stop;
      eol_due  = (LINE_LEN != 0) && (line_inc == LINE_LEN_V) && (kind_q != K_LF);

      nxt_lfsr = lfsr_q;
      case (mode_q)
         2'd1: begin
            nxt_lfsr = lfsr_step(lfsr_q);
            nxt_pay  = nxt_lfsr;
         end
         2'd2:    nxt_pay = FIRST_CHAR;
         default: nxt_pay = (pay_q == LAST_CHAR) ? FIRST_CHAR : pay_q + 8'd1;
      endcase

      case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               mode_d  = mode;
               count_d = count;
               sent_d  = '0;
               line_d  = '0;
               lfsr_d  = LFSR_SEED;
               kind_d  = K_PAYLOAD;
               pay_d   = (mode == 2'd1) ? LFSR_SEED : FIRST_CHAR;
               data_d  = pay_d;
               state_d = S_SEND;
            end
         end

         S_SEND: begin
            if (rdy) begin
               en_d    = 1'b1;
               state_d = S_WAIT_ACC;
            end
         end

         // rdy may still be high from the previous idle period; only its
         // fall proves the sink took the byte.
         S_WAIT_ACC: begin
            if (!rdy) state_d = S_WAIT_DONE;
         end

         S_WAIT_DONE: begin
            if (rdy) begin
               sent_d = sent_inc;
               line_d = line_inc;
               if (run_end) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  if (eol_due) begin
                     kind_d = ((kind_q == K_PAYLOAD) && EOL_CR) ? K_CR : K_LF;
                     data_d = ((kind_q == K_PAYLOAD) && EOL_CR) ? CHAR_CR : CHAR_LF;
                  end else begin
                     if (kind_q == K_LF) line_d = '0;
                     kind_d = K_PAYLOAD;
                     pay_d  = nxt_pay;
                     lfsr_d = nxt_lfsr;
                     data_d = nxt_pay;
                  end
                  gap_d   = GAP_LOAD;
                  state_d = (GAP_CYCLES > 0) ? S_GAP : S_SEND;
               end
            end
         end

         S_GAP: begin
            if (stop) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if (gap_q == '0) begin
               state_d = S_SEND;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         kind_q  <= K_PAYLOAD;
         mode_q  <= 2'd0;
         count_q <= '0;
         sent_q  <= '0;
         line_q  <= '0;
         lfsr_q  <= LFSR_SEED;
         pay_q   <= FIRST_CHAR;
         data_q  <= FIRST_CHAR;
         gap_q   <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         mode_q  <= mode_d;
         count_q <= count_d;
         sent_q  <= sent_d;
         line_q  <= line_d;
         lfsr_q  <= lfsr_d;
         pay_q   <= pay_d;
         data_q  <= data_d;
         gap_q   <= gap_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign en       = en_q;
   assign data_out = data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign sent_cnt = sent_q;

endmodule
